module_uart_reg_ctrl: RTL and testbench
=======================================

Name: module_uart_reg_ctrl

Overview:
- Register-level controller for the UART peripheral. It sits between the CPU register bus and the UART TX/RX engines.
- Holds two registers, CONTROL and DATA, selected by reg_sel_i. CPU writes are steered to the selected register.
- Sequences each transmission: launch, wait for completion, time out, then clear the send bit.
- Captures received bytes and raises status flags for the CPU.

Parameters:
- BUS_W, 32, CPU data bus width.
- DATA_W, 8, UART character width.
- TIMEOUT_CYC, 200000, maximum clk_i cycles to wait for tx_done_i before aborting.

Ports:
- clk_i  in  1  system clock.
- rst_n_i  in  1  synchronous, active-low reset.
- wr_i  in  1  CPU write strobe, one cycle per write.
- reg_sel_i  in  1  register select: 0 = CONTROL, 1 = DATA.
- entrada_i  in  BUS_W  CPU write data.
- salida_o  out  BUS_W  CPU read data for the selected register.
- tx_start_o  out  1  one-cycle launch pulse to the TX engine.
- tx_data_o  out  DATA_W  byte to transmit; stable from tx_start_o until completion.
- tx_busy_i  in  1  TX engine busy.
- tx_done_i  in  1  one-cycle pulse: character fully shifted out.
- rx_valid_i  in  1  one-cycle pulse: new byte on rx_data_i.
- rx_data_i  in  DATA_W  received byte.

Behaviour:
- One clock domain. Reset is synchronous and active-low; clk_i and rst_n_i are the clock and reset port names.
- On reset (rst_n_i=0 at a clk_i edge):
  - All registers are 0.
  - FSM enters IDLE.
  - tx_start_o=0 and tx_data_o=0.
- CONTROL register bits:
  - bit0 SEND: CPU sets it; hardware clears it.
  - bit1 NEW_RX: hardware sets it; CPU clears it by writing 0.
  - bit2 TX_ERR: timeout; sticky.
  - bit3 OVERRUN: sticky.
  - Bits BUS_W-1:4 read 0.
  - A CPU write of 1 to bit2 or bit3 clears that bit.
- DATA register:
  - A CPU write stores entrada_i[DATA_W-1:0] into tx_byte.
  - A read returns rx_byte, zero-extended.
- salida_o is a combinational mux on reg_sel_i, zero latency.
- Write steering: wr_i with reg_sel_i=0 writes CONTROL only; wr_i with reg_sel_i=1 writes DATA only. Never both.
- FSM states: IDLE, LAUNCH, WAIT_DONE, CLEAR.
  - IDLE -> LAUNCH when SEND=1 and tx_busy_i=0. If tx_busy_i=1, stay in IDLE.
  - LAUNCH, one cycle: tx_start_o=1 and tx_data_o<=tx_byte (latched copy). The timeout counter loads 0. Next state is WAIT_DONE.
  - WAIT_DONE:
    - The counter increments each cycle.
    - On tx_done_i, go to CLEAR.
    - If the counter reaches TIMEOUT_CYC-1 without tx_done_i, set TX_ERR and go to CLEAR.
    - If tx_done_i and the timeout occur in the same cycle, tx_done_i wins and TX_ERR is not set.
  - CLEAR, one cycle: SEND<=0, then IDLE.
- Launch latency: SEND written at edge N gives tx_start_o=1 during cycle N+1 (through LAUNCH), provided tx_busy_i=0.
- CPU writes while in LAUNCH, WAIT_DONE or CLEAR:
  - The SEND bit of the write is ignored; a transfer cannot be aborted.
  - Other CONTROL bits are honoured.
  - A DATA write updates tx_byte but does not change tx_data_o.
- CPU write in the same cycle as CLEAR: the hardware clear of SEND wins.
- Receive path: rx_valid_i loads rx_byte<=rx_data_i and sets NEW_RX.
  - If NEW_RX is already 1, also set OVERRUN; the new byte overwrites rx_byte.
  - If rx_valid_i and a CPU write clearing NEW_RX occur in the same cycle, the set wins.
- rx_valid_i is accepted in every FSM state.
- Reset mid-transfer: FSM goes to IDLE and SEND clears. No further tx_start_o is issued.

Decomposition:
- Package uart_ctrl_pkg holds:
  - the state enum type (IDLE, LAUNCH, WAIT_DONE, CLEAR);
  - CONTROL bit-index constants SEND_BIT=0, NEW_RX_BIT=1, TX_ERR_BIT=2, OVERRUN_BIT=3;
  - REG_CONTROL=1'b0 and REG_DATA=1'b1.
- One sub-module, module_uart_tx_timeout: the counter, with clear/enable inputs and an expired output.

Test Plan:
- Reset then read: reg_sel_i=0 and reg_sel_i=1 -> salida_o=32'h0; tx_start_o=0.
- Write DATA=0x41, then CONTROL=0x1, with tx_busy_i=0:
  - tx_start_o pulses once, with tx_data_o=0x41, the cycle after the CONTROL write.
  - After a tx_done_i pulse, CONTROL reads 0x0 within 2 cycles.
- Send pending with tx_busy_i=1 for 10 cycles -> no tx_start_o; the launch occurs 1 cycle after tx_busy_i falls.
- TIMEOUT_CYC=16, no tx_done_i -> after 16 WAIT_DONE cycles CONTROL=0x4 (TX_ERR set, SEND cleared); writing 0x4 clears it.
- Two rx_valid_i pulses (0x55, then 0xAA) without a CPU clear -> DATA reads 0xAA; CONTROL reads 0xA (NEW_RX|OVERRUN).
  - Same-cycle CPU clear of NEW_RX and rx_valid_i -> NEW_RX remains 1.
- Assert rst_n_i=0 during WAIT_DONE, then write DATA=0x7E mid-transfer in a fresh send:
  - After the reset, FSM is in IDLE, CONTROL=0x0, no tx_start_o.
  - In the fresh send, tx_data_o keeps the latched byte until CLEAR.

Source files
------------

// File: rtl/uart_ctrl_pkg.sv
// uart_ctrl_pkg
//   Shared definitions for the UART register controller: transmit FSM
//   encoding, CONTROL register bit positions and register-select codes.
`timescale 1ns/1ps
package uart_ctrl_pkg;

  // Fixed encodings, kept as plain constants so older code can compare
  // against raw state values.
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_LAUNCH    = 2'd1;
  localparam logic [1:0] ST_WAIT_DONE = 2'd2;
  localparam logic [1:0] ST_CLEAR     = 2'd3;

  typedef enum logic [1:0] {
    IDLE      = ST_IDLE,
    LAUNCH    = ST_LAUNCH,
    WAIT_DONE = ST_WAIT_DONE,
    CLEAR     = ST_CLEAR
  } state_e;

  // CONTROL register bit positions
  localparam int unsigned SEND_BIT    = 0;
  localparam int unsigned NEW_RX_BIT  = 1;
  localparam int unsigned TX_ERR_BIT  = 2;
  localparam int unsigned OVERRUN_BIT = 3;

  // reg_sel_i codes
  localparam logic REG_CONTROL = 1'b0;
  localparam logic REG_DATA    = 1'b1;

endpackage

// File: rtl/module_uart_tx_timeout.sv
// module_uart_tx_timeout
//   Transmit watchdog counter. Cleared while the controller launches a
//   character, counts while it waits for completion, and flags expiry when
//   the count reaches TIMEOUT_CYC-1.
// Ports:
//   clk_i, rst_n_i : clock, synchronous active-low reset
//   clr_i          : load 0 (has priority over en_i)
//   en_i           : count one cycle
//   expired_o      : count == TIMEOUT_CYC-1
`timescale 1ns/1ps
module module_uart_tx_timeout #(
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] r_cnt;

  // Holds at LAST rather than wrapping, so expiry stays visible until cleared.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i)                 r_cnt <= '0;
    else if (clr_i)               r_cnt <= '0;
    else if (en_i && !expired_o)  r_cnt <= r_cnt + CW'(1);
  end

  assign expired_o = (r_cnt == LAST);

endmodule

// File: rtl/module_uart_reg_ctrl.sv
// module_uart_reg_ctrl
//   CPU-facing register block for the UART. Holds CONTROL (SEND, NEW_RX,
//   TX_ERR, OVERRUN) and DATA (tx_byte on write, rx_byte on read), sequences
//   one transmission per SEND and captures received bytes.
// Ports:
//   clk_i, rst_n_i        : clock, synchronous active-low reset
//   wr_i, reg_sel_i       : write strobe and register select (0 CONTROL, 1 DATA)
//   entrada_i / salida_o  : CPU write data / combinational read data
//   tx_start_o, tx_data_o : launch pulse and held byte to the TX engine
//   tx_busy_i, tx_done_i  : TX engine busy level and completion pulse
//   rx_valid_i, rx_data_i : RX engine byte strobe and byte
`timescale 1ns/1ps
module module_uart_reg_ctrl
  import uart_ctrl_pkg::*;
#(
  parameter int BUS_W       = 32,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              wr_i,
  input  logic              reg_sel_i,
  input  logic [BUS_W-1:0]  entrada_i,
  output logic [BUS_W-1:0]  salida_o,
  output logic              tx_start_o,
  output logic [DATA_W-1:0] tx_data_o,
  input  logic              tx_busy_i,
  input  logic              tx_done_i,
  input  logic              rx_valid_i,
  input  logic [DATA_W-1:0] rx_data_i
);

  state_e            r_state, w_next;
  logic              r_send, r_new_rx, r_tx_err, r_overrun;
  logic [DATA_W-1:0] r_tx_byte, r_rx_byte, r_tx_data;

  logic w_wr_ctrl, w_wr_data, w_expired, w_timeout;
  logic w_unused_bits;

  assign w_wr_ctrl     = wr_i && (reg_sel_i == REG_CONTROL);
  assign w_wr_data     = wr_i && (reg_sel_i == REG_DATA);
  assign w_unused_bits = ^entrada_i[BUS_W-1:DATA_W];

  module_uart_tx_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .clr_i     (r_state == LAUNCH),
    .en_i      (r_state == WAIT_DONE),
    .expired_o (w_expired)
  );

  // A completion arriving on the expiry cycle counts as success.
  assign w_timeout = (r_state == WAIT_DONE) && w_expired && !tx_done_i;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      if (r_send && !tx_busy_i) w_next = LAUNCH;
      LAUNCH:    w_next = WAIT_DONE;
      WAIT_DONE: if (tx_done_i || w_expired) w_next = CLEAR;
      CLEAR:     w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state   <= IDLE;
      r_send    <= 1'b0;
      r_new_rx  <= 1'b0;
      r_tx_err  <= 1'b0;
      r_overrun <= 1'b0;
      r_tx_byte <= '0;
      r_rx_byte <= '0;
      r_tx_data <= '0;
    end else begin
      r_state <= w_next;

      // Latch on entry to LAUNCH so the byte is already valid alongside
      // tx_start_o and immune to later DATA writes.
      if (r_state == IDLE && w_next == LAUNCH) r_tx_data <= r_tx_byte;

      if (w_wr_data) r_tx_byte <= entrada_i[DATA_W-1:0];

      // SEND is only CPU-writable while idle; CLEAR always wins.
      if (r_state == CLEAR)                   r_send <= 1'b0;
      else if (w_wr_ctrl && r_state == IDLE)  r_send <= entrada_i[SEND_BIT];

      // Hardware set beats a same-cycle CPU clear on every flag.
      if (rx_valid_i)                                  r_new_rx <= 1'b1;
      else if (w_wr_ctrl && !entrada_i[NEW_RX_BIT])    r_new_rx <= 1'b0;

      if (w_timeout)                                   r_tx_err <= 1'b1;
      else if (w_wr_ctrl && entrada_i[TX_ERR_BIT])     r_tx_err <= 1'b0;

      if (rx_valid_i && r_new_rx)                      r_overrun <= 1'b1;
      else if (w_wr_ctrl && entrada_i[OVERRUN_BIT])    r_overrun <= 1'b0;

      if (rx_valid_i) r_rx_byte <= rx_data_i;
    end
  end

  always_comb begin
    salida_o = '0;
    if (reg_sel_i == REG_CONTROL) salida_o[3:0] = {r_overrun, r_tx_err, r_new_rx, r_send};
    else                          salida_o[DATA_W-1:0] = r_rx_byte;
  end

  assign tx_start_o = (r_state == LAUNCH);
  assign tx_data_o  = r_tx_data;

endmodule

// File: tb/tb_module_uart_reg_ctrl.sv
`timescale 1ns/1ps
module tb_module_uart_reg_ctrl;
  localparam int BUS_W = 32, DATA_W = 8, TO = 16;

  logic              clk = 1'b0, rst_n = 1'b0, wr = 1'b0, sel = 1'b0;
  logic [BUS_W-1:0]  ent = '0;
  logic [BUS_W-1:0]  sal;
  logic              tx_start;
  logic [DATA_W-1:0] tx_data;
  logic              busy = 1'b0, done = 1'b0, rxv = 1'b0;
  logic [DATA_W-1:0] rxd = '0;

  int checks = 0, errors = 0;

  // Reference: CONTROL flags, last received byte, and whether the bench has
  // a transfer outstanding (SEND writes are ignored while it does).
  logic m_send, m_nrx, m_err, m_ovr, m_xfer;
  logic [7:0] m_rx;

  module_uart_reg_ctrl #(.BUS_W(BUS_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TO)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .wr_i(wr), .reg_sel_i(sel), .entrada_i(ent),
    .salida_o(sal), .tx_start_o(tx_start), .tx_data_o(tx_data),
    .tx_busy_i(busy), .tx_done_i(done), .rx_valid_i(rxv), .rx_data_i(rxd)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] m_ctrl();
    return {28'h0, m_ovr, m_err, m_nrx, m_send};
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic rd(input logic s, output logic [31:0] v);
    sel = s; #1; v = sal;
  endtask

  task automatic model_reset();
    m_send = 0; m_nrx = 0; m_err = 0; m_ovr = 0; m_xfer = 0; m_rx = 8'h0;
  endtask

  // One clock of CPU/RX activity, with the reference updated from the
  // register rules.
  task automatic cycle(input logic w, input logic s, input logic [31:0] d,
                       input logic rv, input logic [7:0] rb);
    logic wc, n_nrx, n_ovr;
    wr = w; sel = s; ent = d; rxv = rv; rxd = rb;
    step();
    wr = 0; rxv = 0;
    wc    = w && !s;
    n_ovr = (rv && m_nrx) ? 1'b1 : (wc && d[3]) ? 1'b0 : m_ovr;
    n_nrx = rv ? 1'b1 : (wc && !d[1]) ? 1'b0 : m_nrx;
    if (wc && d[2]) m_err = 0;
    if (wc && !m_xfer) m_send = d[0];
    if (rv) m_rx = rb;
    m_ovr = n_ovr; m_nrx = n_nrx;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    rst_n = 0; repeat (3) step(); rst_n = 1;
    model_reset();
    rd(0, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_ctrl got %h exp 0", v); end
    rd(1, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_data got %h exp 0", v); end
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start got %b exp 0", tx_start); end
    checks++; if (tx_data !== 8'h0) begin errors++; $display("FAIL reset_tx_data got %h exp 0", tx_data); end
  endtask

  task automatic test_send_basic();
    logic [31:0] v;
    int first, pulses;
    first = -1; pulses = 0;
    cycle(1, 1, 32'h41, 0, 0);
    cycle(1, 0, 32'h1, 0, 0); m_xfer = 1;
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL send_early got %b exp 0", tx_start); end
    for (int k = 1; k <= 6; k++) begin
      step();
      if (tx_start) begin
        pulses++;
        if (first < 0) first = k;
        checks++; if (tx_data !== 8'h41) begin errors++; $display("FAIL send_data got %h exp 41", tx_data); end
      end
    end
    checks++; if (first != 1 || pulses != 1) begin errors++; $display("FAIL send_launch got first=%0d pulses=%0d exp 1/1", first, pulses); end
    rd(0, v);
    checks++; if (v !== m_ctrl()) begin errors++; $display("FAIL send_busy_ctrl got %h exp %h", v, m_ctrl()); end
    done = 1; step(); done = 0;
    m_send = 0; m_xfer = 0;
    for (int k = 0; k < 2; k++) begin
      rd(0, v);
      if (v !== 32'h0) step();
    end
    rd(0, v);
    checks++; if (v !== m_ctrl()) begin errors++; $display("FAIL send_clear got %h exp %h", v, m_ctrl()); end
  endtask

  task automatic test_busy();
    logic [31:0] v;
    int pulses;
    pulses = 0;
    busy = 1;
    cycle(1, 1, 32'hC3, 0, 0);
    cycle(1, 0, 32'h1, 0, 0); m_xfer = 1;
    repeat (10) begin step(); if (tx_start) pulses++; end
    checks++; if (pulses != 0) begin errors++; $display("FAIL busy_hold got %0d pulses exp 0", pulses); end
    rd(0, v);
    checks++; if (v !== m_ctrl()) begin errors++; $display("FAIL busy_ctrl got %h exp %h", v, m_ctrl()); end
    busy = 0; step();
    checks++; if (tx_start !== 1'b1 || tx_data !== 8'hC3) begin errors++; $display("FAIL busy_launch got %b/%h exp 1/c3", tx_start, tx_data); end
    step(); done = 1; step(); done = 0; step();
    m_send = 0; m_xfer = 0;
    rd(0, v);
    checks++; if (v !== m_ctrl()) begin errors++; $display("FAIL busy_end got %h exp %h", v, m_ctrl()); end
  endtask

  task automatic test_timeout();
    logic [31:0] v;
    int first;
    first = -1;
    cycle(1, 1, 32'h5A, 0, 0);
    cycle(1, 0, 32'h1, 0, 0); m_xfer = 1;
    step();
    checks++; if (tx_start !== 1'b1) begin errors++; $display("FAIL to_launch got %b exp 1", tx_start); end
    for (int k = 1; k <= TO + 4 && first < 0; k++) begin
      step(); rd(0, v);
      if (v[2]) first = k;
    end
    checks++; if (first != TO + 1) begin errors++; $display("FAIL to_cycle got %0d exp %0d", first, TO + 1); end
    m_err = 1;
    step(); m_send = 0; m_xfer = 0;
    rd(0, v);
    checks++; if (v !== 32'h4) begin errors++; $display("FAIL to_ctrl got %h exp 4", v); end
    cycle(1, 0, 32'h4, 0, 0);
    rd(0, v);
    checks++; if (v !== m_ctrl()) begin errors++; $display("FAIL to_w1c got %h exp %h", v, m_ctrl()); end
  endtask

  task automatic test_tie();
    logic [31:0] v;
    cycle(1, 1, 32'h66, 0, 0);
    cycle(1, 0, 32'h1, 0, 0); m_xfer = 1;
    step();
    repeat (TO) step();
    done = 1; step(); done = 0;
    rd(0, v);
    checks++; if (v !== 32'h1) begin errors++; $display("FAIL tie_clear got %h exp 1", v); end
    step(); m_send = 0; m_xfer = 0;
    rd(0, v);
    checks++; if (v !== m_ctrl()) begin errors++; $display("FAIL tie_end got %h exp %h", v, m_ctrl()); end
  endtask

  task automatic test_rx();
    logic [31:0] v;
    cycle(0, 0, 0, 1, 8'h55);
    cycle(0, 0, 0, 1, 8'hAA);
    rd(1, v);
    checks++; if (v !== 32'hAA) begin errors++; $display("FAIL rx_data got %h exp aa", v); end
    rd(0, v);
    checks++; if (v !== 32'hA) begin errors++; $display("FAIL rx_ovr got %h exp a", v); end
    cycle(1, 0, 32'h0, 1, 8'h3C);
    rd(0, v);
    checks++; if (v !== 32'hA) begin errors++; $display("FAIL rx_setwins got %h exp a", v); end
    rd(1, v);
    checks++; if (v !== 32'h3C) begin errors++; $display("FAIL rx_data2 got %h exp 3c", v); end
    cycle(1, 0, 32'h8, 0, 0);
    rd(0, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL rx_clear got %h exp 0", v); end
  endtask

  task automatic test_random_regs();
    logic [31:0] v, d;
    logic w, s, rv;
    for (int i = 0; i < 300; i++) begin
      w  = ($urandom_range(0, 2) == 0);
      s  = 1'($urandom_range(0, 1));
      d  = $urandom; d[0] = 1'b0;
      rv = ($urandom_range(0, 3) == 0);
      cycle(w, s, d, rv, 8'($urandom));
      rd(0, v);
      checks++; if (v !== m_ctrl()) begin errors++; $display("FAIL rnd_ctrl i=%0d got %h exp %h", i, v, m_ctrl()); end
      rd(1, v);
      checks++; if (v !== {24'h0, m_rx}) begin errors++; $display("FAIL rnd_data i=%0d got %h exp %h", i, v, {24'h0, m_rx}); end
    end
    cycle(1, 0, 32'hE, 0, 0);
  endtask

  task automatic test_random_send();
    logic [31:0] v;
    logic [7:0] b;
    int dly, pulses, bad;
    for (int it = 0; it < 8; it++) begin
      b = 8'($urandom); dly = $urandom_range(2, TO - 3); pulses = 0; bad = 0;
      cycle(1, 1, {24'h0, b}, 0, 0);
      cycle(1, 0, 32'h1, 0, 0); m_xfer = 1;
      step();
      if (tx_start) pulses++;
      if (tx_data !== b) bad++;
      for (int k = 0; k < dly; k++) begin
        if (k == 0)      cycle(1, 1, {24'h0, ~b}, 0, 0);
        else if (k == 1) cycle(1, 0, 32'h0, 0, 0);
        else             step();
        if (tx_start) pulses++;
        if (tx_data !== b) bad++;
      end
      done = 1; step(); done = 0;
      if (tx_data !== b) bad++;
      rd(0, v);
      checks++; if (v !== 32'h1) begin errors++; $display("FAIL rs_send_held it=%0d got %h exp 1", it, v); end
      step(); m_send = 0; m_xfer = 0;
      rd(0, v);
      checks++; if (v !== m_ctrl()) begin errors++; $display("FAIL rs_end it=%0d got %h exp %h", it, v, m_ctrl()); end
      checks++; if (pulses != 1 || bad != 0) begin errors++; $display("FAIL rs_xfer it=%0d got pulses=%0d bad=%0d exp 1/0", it, pulses, bad); end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    int pulses, bad;
    pulses = 0; bad = 0;
    cycle(1, 1, 32'h99, 0, 0);
    cycle(1, 0, 32'h1, 0, 0); m_xfer = 1;
    repeat (3) step();
    rst_n = 0; step(); rst_n = 1;
    model_reset();
    rd(0, v);
    checks++; if (v !== 32'h0 || tx_data !== 8'h0) begin errors++; $display("FAIL rm_state got ctrl=%h txd=%h exp 0/0", v, tx_data); end
    repeat (TO + 4) begin step(); if (tx_start) pulses++; end
    checks++; if (pulses != 0) begin errors++; $display("FAIL rm_nostart got %0d pulses exp 0", pulses); end
    cycle(1, 1, 32'h3C, 0, 0);
    cycle(1, 0, 32'h1, 0, 0); m_xfer = 1;
    step();
    checks++; if (tx_start !== 1'b1 || tx_data !== 8'h3C) begin errors++; $display("FAIL rm_launch got %b/%h exp 1/3c", tx_start, tx_data); end
    cycle(1, 1, 32'h7E, 0, 0);
    repeat (3) begin step(); if (tx_data !== 8'h3C) bad++; end
    done = 1; step(); done = 0;
    if (tx_data !== 8'h3C) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL rm_hold got %0d bad cycles exp 0", bad); end
    step(); m_send = 0; m_xfer = 0;
    rd(0, v);
    checks++; if (v !== m_ctrl()) begin errors++; $display("FAIL rm_end got %h exp %h", v, m_ctrl()); end
    rd(1, v);
    checks++; if (v !== {24'h0, m_rx}) begin errors++; $display("FAIL rm_data got %h exp %h", v, {24'h0, m_rx}); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_send_basic();
    test_busy();
    test_timeout();
    test_tie();
    test_rx();
    test_random_regs();
    test_random_send();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
